// File: rtl/glip_uart_pkg.sv
// glip_uart_pkg: shared constants, state types and helpers for the GLIP
// UART PHY.
//   PAR_*          cfg_parity encodings (2'b11 also means no parity)
//   OVERSAMPLE     ticks per bit; SAMPLE_A/B/C are the three mid-bit ticks
//   tx_state_t     transmit FSM states
//   rx_state_t     receive FSM states
package glip_uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_A   = 4'd7;
    localparam logic [3:0] SAMPLE_B   = 4'd8;
    localparam logic [3:0] SAMPLE_C   = 4'd9;
    localparam logic [3:0] BIT_LAST   = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

    function automatic logic has_parity(input logic [1:0] par);
        return (par == PAR_ODD) || (par == PAR_EVEN);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/glip_uart_fifo.sv
// glip_uart_fifo: synchronous first-word-fall-through FIFO with occupancy.
//   wr_en/wr_data  push; ignored when full unless a pop happens in the same cycle
//   rd_en/rd_data  pop; rd_data shows the head whenever empty=0
//   full/empty     occupancy flags
//   count          number of stored entries, 0..DEPTH
module glip_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // Pop is evaluated first so a push into a full FIFO succeeds when the
    // head leaves in the same cycle.
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/glip_uart_phy.sv
// glip_uart_phy: configurable UART PHY (data bits by parameter, parity and
// stop bits and 16x-oversampled baud divisor at runtime) with RX FIFO and
// RTS/CTS flow control, all in the clk_io domain.
//   cfg_*            frame configuration, captured at the start of each frame
//   tx_*             egress byte stream from glip_uart_control
//   rx_*             ingress byte stream (FWFT from the RX FIFO)
//   uart_rx/uart_tx  serial pins; uart_cts_n/uart_rts_n flow control pins
//   err_*            sticky receive errors, cleared by err_clear
// Stream handshake (tx_* and rx_*): a word moves on every rising clk_io edge
// where valid and ready are both 1; valid never depends on ready, and the
// data is stable whenever valid is 1.
module glip_uart_phy
    import glip_uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int RX_FIFO_DEPTH = 16,
    parameter int RTS_MARGIN    = 4,
    parameter int DIV_WIDTH     = 16
) (
    input  logic                  clk_io,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  cfg_divisor,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    input  logic                  uart_cts_n,
    output logic                  uart_rts_n,
    output logic                  err_frame,
    output logic                  err_parity,
    output logic                  err_overrun,
    input  logic                  err_clear
);

    localparam int BC_W = $clog2(DATA_WIDTH);
    localparam int CW   = $clog2(RX_FIFO_DEPTH) + 1;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic                 cts_meta_q, cts_sync_q;
    logic [DIV_WIDTH-1:0] cfg_divm1;

    tx_state_t            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_div_q, tx_div_d, tx_divm1_q, tx_divm1_d;
    logic [3:0]           tx_os_q, tx_os_d;
    logic [BC_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
    logic                 tx_stop2_q, tx_stop2_d, uart_tx_q, uart_tx_d;

    rx_state_t            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_div_q, rx_div_d, rx_divm1_q, rx_divm1_d;
    logic [3:0]           rx_os_q, rx_os_d;
    logic [BC_W-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]           rx_par_q, rx_par_d;
    logic                 rx_s7_q, rx_s7_d, rx_s8_q, rx_s8_d;
    logic                 rx_maj, rx_ones, rx_push, set_frame, set_parity, set_overrun;

    logic                 err_frame_q, err_frame_d, err_parity_q, err_parity_d;
    logic                 err_overrun_q, err_overrun_d, rts_n_q, rts_n_d;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;

    // A divisor of 0 behaves like 1 (a tick every cycle).
    assign cfg_divm1 = (cfg_divisor == '0) ? '0 : cfg_divisor - 1'b1;
    assign tx_ready  = (tx_state_q == TX_IDLE) & ~cts_sync_q;

    // ---------------- transmit ----------------
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_div_d     = tx_div_q;
        tx_divm1_d   = tx_divm1_q;
        tx_os_d      = tx_os_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_stop2_d   = tx_stop2_q;
        if (tx_state_q == TX_IDLE) begin
            if (tx_valid && tx_ready) begin
                tx_state_d   = TX_START;
                tx_div_d     = cfg_divm1;
                tx_divm1_d   = cfg_divm1;
                tx_os_d      = '0;
                tx_bit_d     = '0;
                tx_shift_d   = tx_data;
                tx_par_en_d  = has_parity(cfg_parity);
                tx_par_bit_d = (cfg_parity == PAR_EVEN) ? (^tx_data) : ~(^tx_data);
                tx_stop2_d   = cfg_stop2;
            end
        end else if (tx_div_q == '0) begin
            tx_div_d = tx_divm1_q;
            tx_os_d  = tx_os_q + 1'b1;
            if (tx_os_q == BIT_LAST) begin
                case (tx_state_q)
                    TX_START: tx_state_d = TX_DATA;
                    TX_DATA: begin
                        if (tx_bit_q == BC_W'(DATA_WIDTH - 1)) begin
                            tx_bit_d   = '0;
                            tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_bit_d   = tx_bit_q + 1'b1;
                            tx_shift_d = tx_shift_q >> 1;
                        end
                    end
                    TX_PARITY: tx_state_d = TX_STOP;
                    TX_STOP: begin
                        // tx_bit counts stop bits already sent
                        if (tx_stop2_q && (tx_bit_q == '0)) tx_bit_d = 1'b1;
                        else                                tx_state_d = TX_IDLE;
                    end
                    default: tx_state_d = TX_IDLE;
                endcase
            end
        end else begin
            tx_div_d = tx_div_q - 1'b1;
        end
        // Line level follows the next state so it is registered with it.
        case (tx_state_d)
            TX_START:  uart_tx_d = 1'b0;
            TX_DATA:   uart_tx_d = tx_shift_d[0];
            TX_PARITY: uart_tx_d = tx_par_bit_d;
            default:   uart_tx_d = 1'b1;
        endcase
    end

    // ---------------- receive ----------------
    assign rx_maj  = maj3(rx_s7_q, rx_s8_q, rx_sync_q);
    assign rx_ones = (^rx_shift_q) ^ rx_maj;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_divm1_d = rx_divm1_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_s7_d    = rx_s7_q;
        rx_s8_d    = rx_s8_q;
        rx_push    = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = cfg_divm1;
                    rx_divm1_d = cfg_divm1;
                    rx_os_d    = '0;
                    rx_bit_d   = '0;
                    rx_par_d   = cfg_parity;
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: begin
                if (rx_div_q == '0) begin
                    rx_div_d = rx_divm1_q;
                    rx_os_d  = rx_os_q + 1'b1;
                    if (rx_os_q == SAMPLE_A) rx_s7_d = rx_sync_q;
                    if (rx_os_q == SAMPLE_B) rx_s8_d = rx_sync_q;
                    if (rx_os_q == SAMPLE_C) begin
                        case (rx_state_q)
                            RX_START: if (rx_maj) rx_state_d = RX_IDLE;
                            RX_DATA:  rx_shift_d = {rx_maj, rx_shift_q[DATA_WIDTH-1:1]};
                            RX_PARITY: set_parity = (rx_par_q == PAR_EVEN) ? rx_ones : ~rx_ones;
                            RX_STOP: begin
                                if (rx_maj) begin
                                    rx_push    = 1'b1;
                                    rx_state_d = RX_IDLE;
                                end else begin
                                    set_frame  = 1'b1;
                                    rx_state_d = RX_WAIT_IDLE;
                                end
                            end
                            default: rx_state_d = RX_IDLE;
                        endcase
                    end else if (rx_os_q == BIT_LAST) begin
                        case (rx_state_q)
                            RX_START: rx_state_d = RX_DATA;
                            RX_DATA: begin
                                if (rx_bit_q == BC_W'(DATA_WIDTH - 1))
                                    rx_state_d = has_parity(rx_par_q) ? RX_PARITY : RX_STOP;
                                else
                                    rx_bit_d = rx_bit_q + 1'b1;
                            end
                            RX_PARITY: rx_state_d = RX_STOP;
                            default:   rx_state_d = rx_state_q;
                        endcase
                    end
                end else begin
                    rx_div_d = rx_div_q - 1'b1;
                end
            end
        endcase
    end

    // ---------------- errors and flow control ----------------
    assign set_overrun = rx_push & fifo_full & ~rx_ready;

    always_comb begin
        err_frame_d   = (err_frame_q   & ~err_clear) | set_frame;
        err_parity_d  = (err_parity_q  & ~err_clear) | set_parity;
        err_overrun_d = (err_overrun_q & ~err_clear) | set_overrun;
        rts_n_d       = (fifo_count >= CW'(RX_FIFO_DEPTH - RTS_MARGIN));
    end

    glip_uart_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk_io),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (rx_shift_q),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk_io) begin
        if (rst) begin
            {rx_meta_q, rx_sync_q, rx_prev_q} <= 3'b111;
            {cts_meta_q, cts_sync_q}          <= 2'b11;
            tx_state_q    <= TX_IDLE;
            tx_div_q      <= '0;
            tx_divm1_q    <= '0;
            tx_os_q       <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_en_q   <= 1'b0;
            tx_par_bit_q  <= 1'b0;
            tx_stop2_q    <= 1'b0;
            uart_tx_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_div_q      <= '0;
            rx_divm1_q    <= '0;
            rx_os_q       <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_par_q      <= PAR_NONE;
            rx_s7_q       <= 1'b1;
            rx_s8_q       <= 1'b1;
            err_frame_q   <= 1'b0;
            err_parity_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            rts_n_q       <= 1'b1;
        end else begin
            {rx_meta_q, rx_sync_q, rx_prev_q} <= {uart_rx, rx_meta_q, rx_sync_q};
            {cts_meta_q, cts_sync_q}          <= {uart_cts_n, cts_meta_q};
            tx_state_q    <= tx_state_d;
            tx_div_q      <= tx_div_d;
            tx_divm1_q    <= tx_divm1_d;
            tx_os_q       <= tx_os_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_par_bit_q  <= tx_par_bit_d;
            tx_stop2_q    <= tx_stop2_d;
            uart_tx_q     <= uart_tx_d;
            rx_state_q    <= rx_state_d;
            rx_div_q      <= rx_div_d;
            rx_divm1_q    <= rx_divm1_d;
            rx_os_q       <= rx_os_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_q      <= rx_par_d;
            rx_s7_q       <= rx_s7_d;
            rx_s8_q       <= rx_s8_d;
            err_frame_q   <= err_frame_d;
            err_parity_q  <= err_parity_d;
            err_overrun_q <= err_overrun_d;
            rts_n_q       <= rts_n_d;
        end
    end

    assign uart_tx     = uart_tx_q;
    assign uart_rts_n  = rts_n_q;
    assign rx_valid    = ~fifo_empty;
    assign err_frame   = err_frame_q;
    assign err_parity  = err_parity_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_glip_uart_phy.sv
// tb_glip_uart_phy: directed plus randomized bench for glip_uart_phy. One
// 8-bit instance (optionally looped back uart_tx->uart_rx) and one 7-bit
// instance used for the 7E2 transmit frame. Expected line waveforms come from
// a frame model that lists the bits of a frame from the format rules.
module tb_glip_uart_phy;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic [15:0] cfg_div;
    logic [1:0]  cfg_par;
    logic        cfg_stop2;
    logic        cts_n, rx_ready, err_clear, loop_en, rx_drv;

    logic [7:0]  a_tx_data, a_rx_data;
    logic        a_tx_valid, a_tx_ready, a_rx_valid, a_uart_tx, a_rts_n;
    logic        a_err_f, a_err_p, a_err_o;
    logic        rx_line;

    logic [6:0]  b_tx_data, b_rx_data;
    logic        b_tx_valid, b_tx_ready, b_rx_valid, b_uart_tx, b_rts_n;
    logic        b_err_f, b_err_p, b_err_o;

    assign rx_line = loop_en ? a_uart_tx : rx_drv;

    glip_uart_phy #(.DATA_WIDTH(8)) u_dut (
        .clk_io(clk), .rst(rst), .cfg_divisor(cfg_div), .cfg_parity(cfg_par),
        .cfg_stop2(cfg_stop2), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .rx_ready(rx_ready), .uart_rx(rx_line), .uart_tx(a_uart_tx),
        .uart_cts_n(cts_n), .uart_rts_n(a_rts_n), .err_frame(a_err_f),
        .err_parity(a_err_p), .err_overrun(a_err_o), .err_clear(err_clear)
    );

    glip_uart_phy #(.DATA_WIDTH(7)) u_dut7 (
        .clk_io(clk), .rst(rst), .cfg_divisor(cfg_div), .cfg_parity(cfg_par),
        .cfg_stop2(cfg_stop2), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .rx_ready(rx_ready), .uart_rx(1'b1), .uart_tx(b_uart_tx),
        .uart_cts_n(cts_n), .uart_rts_n(b_rts_n), .err_frame(b_err_f),
        .err_parity(b_err_p), .err_overrun(b_err_o), .err_clear(err_clear)
    );

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       frame_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame model: start 0, data LSB first, optional parity, stop bit(s).
    task automatic make_frame(input logic [8:0] data, input int w, input logic [1:0] par,
                              input logic stop2, input logic bad_stop, input logic flip_par);
        int   ones;
        logic pb;
        ones = 0;
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            frame_q.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (par == 2'b01 || par == 2'b10) begin
            // even: parity bit equals the data ones count mod 2; odd: its inverse
            pb = (ones % 2 == 1);
            if (par == 2'b01) pb = ~pb;
            frame_q.push_back(pb ^ flip_par);
        end
        frame_q.push_back(~bad_stop);
        if (stop2) frame_q.push_back(1'b1);
    endtask

    function automatic int bit_cycles();
        return 16 * ((cfg_div == 16'd0) ? 1 : int'(cfg_div));
    endfunction

    // ---------------- drivers ----------------
    task automatic tx_frame(input logic sel, input logic [8:0] data, input int w,
                            input int raise_cts_at, output int low_run);
        int n, per, bad;
        make_frame(data, w, cfg_par, cfg_stop2, 1'b0, 1'b0);
        per = bit_cycles();
        if (sel) begin b_tx_data = data[6:0]; b_tx_valid = 1'b1; end
        else     begin a_tx_data = data[7:0]; a_tx_valid = 1'b1; end
        n = 0;
        while (((sel ? b_tx_ready : a_tx_ready) !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx_accept_within_budget", 32'(n < 2000), 32'd1);
        @(negedge clk);
        a_tx_valid = 1'b0;
        b_tx_valid = 1'b0;
        bad = 0;
        low_run = 0;
        for (int k = 0; k < frame_q.size() * per; k++) begin
            if (k == raise_cts_at) cts_n = 1'b1;
            if ((sel ? b_uart_tx : a_uart_tx) !== frame_q[k / per]) bad++;
            if ((sel ? b_tx_ready : a_tx_ready) !== 1'b0) bad++;
            if ((sel ? b_uart_tx : a_uart_tx) === 1'b0 && low_run == k) low_run++;
            @(negedge clk);
        end
        check("tx_waveform_bad_cycles", 32'(bad), 32'd0);
        check("tx_line_idle_after_frame", 32'(sel ? b_uart_tx : a_uart_tx), 32'd1);
    endtask

    task automatic drive_frame(input int per);
        foreach (frame_q[i]) begin
            rx_drv = frame_q[i];
            repeat (per) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check({tag, "_rx_valid"}, 32'(a_rx_valid), 32'd1);
        check({tag, "_rx_data"}, 32'(a_rx_data), 32'(e));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int low, n, bad;
        logic [7:0] d;
        rst = 1'b1; cfg_div = 16'd4; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        cts_n = 1'b0; rx_ready = 1'b0; err_clear = 1'b0; loop_en = 1'b1; rx_drv = 1'b1;
        a_tx_data = '0; a_tx_valid = 1'b0; b_tx_data = '0; b_tx_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_uart_tx", 32'(a_uart_tx), 32'd1);
        check("reset_rts_n", 32'(a_rts_n), 32'd1);
        check("reset_tx_ready", 32'(a_tx_ready), 32'd0);
        check("reset_rx_valid", 32'(a_rx_valid), 32'd0);
        check("reset_errors", 32'({a_err_f, a_err_p, a_err_o}), 32'd0);
        check("reset_uart_tx_w7", 32'(b_uart_tx), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rts_low_after_reset", 32'(a_rts_n), 32'd0);
        repeat (3) @(negedge clk);
        check("tx_ready_after_cts_sync", 32'(a_tx_ready), 32'd1);

        // loopback 8N1, D=4
        tx_frame(1'b0, 9'h0A5, 8, -1, low);
        check("start_bit_low_cycles_A5", 32'(low), 32'd64);
        check("tx_ready_after_A5", 32'(a_tx_ready), 32'd1);
        exp_q.push_back(8'hA5);
        tx_frame(1'b0, 9'h03C, 8, -1, low);
        exp_q.push_back(8'h3C);
        pop_check("loop_A5");
        pop_check("loop_3C");
        check("loop_no_errors", 32'({a_err_f, a_err_p, a_err_o}), 32'd0);

        // 7E2 on the 7-bit instance; tx_ready returns 11*64+1 cycles after accept
        cfg_par = 2'b10; cfg_stop2 = 1'b1;
        tx_frame(1'b1, 9'h055, 7, -1, low);
        check("w7_tx_ready_at_11x64p1", 32'(b_tx_ready), 32'd1);

        // randomized loopback frames
        for (int i = 0; i < 6; i++) begin
            cfg_div   = 16'($urandom_range(0, 4));
            cfg_par   = 2'($urandom_range(0, 3));
            cfg_stop2 = 1'($urandom_range(0, 1));
            d         = 8'($urandom_range(0, 255));
            tx_frame(1'b0, {1'b0, d}, 8, -1, low);
            exp_q.push_back(d);
            pop_check("rand_loop");
        end
        check("rand_no_errors", 32'({a_err_f, a_err_p, a_err_o}), 32'd0);

        // framing error: 0x81 with stop bit 0
        loop_en = 1'b0; cfg_div = 16'd4; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        make_frame(9'h081, 8, 2'b00, 1'b0, 1'b1, 1'b0);
        drive_frame(64);
        repeat (64) @(negedge clk);
        check("frame_err_set", 32'(a_err_f), 32'd1);
        check("frame_err_no_word", 32'(a_rx_valid), 32'd0);
        clear_errors();
        check("frame_err_cleared", 32'(a_err_f), 32'd0);

        // odd parity 0x01: correct parity bit, then inverted parity bit
        cfg_par = 2'b01;
        make_frame(9'h001, 8, 2'b01, 1'b0, 1'b0, 1'b0);
        drive_frame(64);
        check("odd_par_good_no_err", 32'(a_err_p), 32'd0);
        exp_q.push_back(8'h01);
        pop_check("odd_par_good");
        make_frame(9'h001, 8, 2'b01, 1'b0, 1'b0, 1'b1);
        drive_frame(64);
        check("odd_par_bad_err", 32'(a_err_p), 32'd1);
        exp_q.push_back(8'h01);
        pop_check("odd_par_bad_word_kept");
        clear_errors();
        check("errors_cleared", 32'({a_err_f, a_err_p, a_err_o}), 32'd0);

        // FIFO fill, RTS threshold and overrun at D=1
        cfg_div = 16'd1; cfg_par = 2'b00;
        for (int i = 1; i <= 17; i++) begin
            d = 8'($urandom_range(0, 255));
            make_frame({1'b0, d}, 8, 2'b00, 1'b0, 1'b0, 1'b0);
            drive_frame(16);
            if (i <= 16) exp_q.push_back(d);
            if (i == 11) check("rts_low_at_11", 32'(a_rts_n), 32'd0);
            if (i == 12) check("rts_high_at_12", 32'(a_rts_n), 32'd1);
            if (i == 16) check("no_overrun_at_16", 32'(a_err_o), 32'd0);
        end
        check("overrun_at_17", 32'(a_err_o), 32'd1);
        check("count_full_16", 32'(u_dut.u_rx_fifo.count), 32'd16);
        pop_check("fifo_pop_first");
        check("count_after_pop_15", 32'(u_dut.u_rx_fifo.count), 32'd15);
        check("rts_still_high_15", 32'(a_rts_n), 32'd1);
        while (exp_q.size() > 0) pop_check("fifo_drain");
        check("fifo_empty_after_drain", 32'(a_rx_valid), 32'd0);
        @(negedge clk);
        check("rts_low_after_drain", 32'(a_rts_n), 32'd0);
        clear_errors();

        // CTS blocks accept; raising CTS mid-frame lets the frame finish
        loop_en = 1'b1; cfg_div = 16'd4; cts_n = 1'b1;
        repeat (4) @(negedge clk);
        a_tx_data = 8'h5A; a_tx_valid = 1'b1;
        bad = 0;
        repeat (100) begin
            if (a_tx_ready !== 1'b0 || a_uart_tx !== 1'b1) bad++;
            @(negedge clk);
        end
        check("cts_blocks_tx", 32'(bad), 32'd0);
        cts_n = 1'b0;
        tx_frame(1'b0, 9'h05A, 8, 200, low);
        check("cts_high_no_ready", 32'(a_tx_ready), 32'd0);
        exp_q.push_back(8'h5A);
        pop_check("cts_frame_rx");
        cts_n = 1'b0;

        // 3-cycle glitch on idle uart_rx
        loop_en = 1'b0;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_word", 32'(a_rx_valid), 32'd0);
        check("glitch_no_error", 32'({a_err_f, a_err_p, a_err_o}), 32'd0);

        // reset in the middle of a 0x00 frame
        loop_en = 1'b1; a_tx_data = 8'h00; a_tx_valid = 1'b1;
        n = 0;
        while (a_tx_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        a_tx_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("midframe_line_low", 32'(a_uart_tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_aborts_tx", 32'(a_uart_tx), 32'd1);
        check("reset_rts_high", 32'(a_rts_n), 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("after_reset_rx_empty", 32'(a_rx_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
